ov7670_capture_left: RTL and testbench
======================================

// Module: ov7670_capture_left
// PURPOSE
//  Downstream of the left-camera OV7670 controller: once the sensor is configured, captures
//  the PCLK-timed DVP stream (vsync/href/d), packs byte pairs into RGB565 pixels, optionally
//  subsamples 2:1, and writes pixels with linear addresses into the left frame-buffer BRAM.
//  Flags malformed lines and buffer overflow for the stereo matcher and debug LEDs.
// PARAMETERS
//  H_PIXELS   640  active pixels per href line (2 bytes each)
//  V_LINES    480  active lines per frame
//  SUBSAMPLE  2    1 = keep every pixel; 2 = keep even x and even y only
//  ADDR_W     17   frame-buffer address width; ≥ clog2((H_PIXELS/SUBSAMPLE)*(V_LINES/SUBSAMPLE))
// PORTS
//  clk              in   1       camera PCLK, the only clock
//  reset            in   1       asynchronous, active-high
//  config_finished  in   1       from ov7670_controller_left; capture enabled while high
//  vsync            in   1       camera VSYNC, high = frame blanking
//  href             in   1       camera HREF, high = active line bytes
//  d                in   8       camera data byte
//  we               out  1       one-cycle frame-buffer write strobe
//  addr             out  ADDR_W  write address, valid with we
//  dout             out  16      RGB565 pixel {first byte, second byte}, valid with we
//  frame_done       out  1       one-cycle pulse at end of each captured frame
//  line_err         out  1       sticky per frame: a line had byte count != 2*H_PIXELS
//  overflow         out  1       sticky per frame: write suppressed past last address
//  capturing        out  1       high in ACTIVE state
// BEHAVIOUR
//  - Reset: all outputs 0, byte phase 0, x/y counters 0, state WAIT_CFG. Reset mid-frame
//    abandons the frame; no write issues until a fresh vsync falling edge.
//  - vsync, href, d registered once (vs_r, hr_r, d_r); all logic uses registered copies.
//  - FSM: WAIT_CFG -> WAIT_FRAME when config_finished=1.
//    WAIT_FRAME -> ACTIVE on vs_r falling edge (1->0); clears addr, x, y, line_err, overflow.
//    ACTIVE -> WAIT_FRAME on vs_r rising edge; frame_done=1 for exactly that cycle.
//    Any state -> WAIT_CFG when config_finished=0 (resend); no frame_done, we forced 0.
//  - Byte packing (ACTIVE, hr_r=1): phase toggles each cycle; phase 0 latches hi=d_r;
//    phase 1 forms pixel {hi,d_r}, increments x. Pin-to-we latency: 2 clk edges after
//    the second byte is on d.
//  - Write: we=1 one cycle when pixel formed and keep=1 and addr_next <= MAX_ADDR, where
//    keep = (SUBSAMPLE==1) | (~x[0] & ~y[0]); MAX_ADDR=(H_PIXELS/SUBSAMPLE)*(V_LINES/SUBSAMPLE)-1.
//    addr presented is the current count; count increments after each write.
//    Kept pixel with count already past MAX_ADDR: no we, overflow<=1.
//  - hr_r falling edge: if phase=1 (odd byte) byte dropped; if x != H_PIXELS, line_err<=1;
//    x<=0, phase<=0, y<=y+1 (y saturates at V_LINES; lines beyond also set overflow).
//  - href high outside ACTIVE ignored. vs_r rise while hr_r=1 ends frame; partial pixel dropped.
//  - line_err/overflow held until next frame start or reset; counters unsigned, no wrap.
// STRUCTURE
//  - Package ov7670_pkg: state encoding (WAIT_CFG, WAIT_FRAME, ACTIVE), RGB565 field
//    localparams (R 15:11, G 10:5, B 4:0), shared with the right-camera capture.
//  - Sub-module ov7670_byte_assembler: phase toggle + hi latch -> pix_valid/pix strobe.
//  - Top holds FSM, edge detects, x/y/addr counters, keep/overflow logic.
// TESTING
//  1 Reset then config_finished=0, full frame driven -> we never 1, capturing=0.
//  2 H=4,V=2,S=1: bytes 0x12,0x34.. per line -> 8 writes, dout 0x1234.., addr 0..7, frame_done once.
//  3 H=4,V=4,S=2 -> writes only x,y even: 4 writes, addr 0..3, overflow=0.
//  4 Line with 7 bytes (H=4) -> last byte dropped, line_err=1, next frame start clears it.
//  5 Extra line beyond V_LINES -> no writes past MAX_ADDR, overflow=1, addr stays MAX_ADDR+1.
//  6 Assert reset mid-line, release -> outputs 0, writes resume only after next vsync fall at addr 0.

Source files
------------

// File: rtl/ov7670_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ov7670_pkg : capture FSM encoding and RGB565 field positions       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package ov7670_pkg;

  typedef enum logic [1:0] {
    WAIT_CFG   = 2'd0,
    WAIT_FRAME = 2'd1,
    ACTIVE     = 2'd2
  } state_t;

  localparam int RGB565_R_MSB = 15;
  localparam int RGB565_R_LSB = 11;
  localparam int RGB565_G_MSB = 10;
  localparam int RGB565_G_LSB = 5;
  localparam int RGB565_B_MSB = 4;
  localparam int RGB565_B_LSB = 0;

endpackage
`default_nettype wire

// File: rtl/ov7670_capture_left_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ov7670_capture_left_if : DVP input and frame-buffer write bundle   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface ov7670_capture_left_if #(
  parameter int ADDR_W = 17
);
  logic              config_finished;
  logic              vsync;
  logic              href;
  logic [7:0]        d;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       dout;
  logic              frame_done;
  logic              line_err;
  logic              overflow;
  logic              capturing;

  modport master (
    input  config_finished, vsync, href, d,
    output we, addr, dout, frame_done, line_err, overflow, capturing
  );

  modport slave (
    output config_finished, vsync, href, d,
    input  we, addr, dout, frame_done, line_err, overflow, capturing
  );
endinterface
`default_nettype wire

// File: rtl/ov7670_byte_assembler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ov7670_byte_assembler : pairs DVP bytes into 16-bit pixels         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ov7670_byte_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic [7:0]  d_i,
  output logic        pix_valid_o,
  output logic [15:0] pix_o
);

  logic       phase_q, phase_d;
  logic [7:0] hi_q, hi_d;

  // Dropping en_i clears the phase, so a half pixel never survives a line end.
  always_comb begin
    phase_d = 1'b0;
    hi_d    = hi_q;
    if (en_i) begin
      phase_d = ~phase_q;
      if (!phase_q) hi_d = d_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= 1'b0;
      hi_q    <= 8'h00;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
    end
  end

  assign pix_valid_o = en_i & phase_q;
  assign pix_o       = {hi_q, d_i};

endmodule
`default_nettype wire

// File: rtl/ov7670_capture_left.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ov7670_capture_left : left-camera DVP capture into frame buffer    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ov7670_capture_left
  import ov7670_pkg::*;
#(
  parameter int H_PIXELS  = 640,
  parameter int V_LINES   = 480,
  parameter int SUBSAMPLE = 2,
  parameter int ADDR_W    = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  ov7670_capture_left_if.master bus
);

  localparam int unsigned MAX_ADDR = (H_PIXELS/SUBSAMPLE)*(V_LINES/SUBSAMPLE) - 1;
  localparam int X_W = $clog2(H_PIXELS + 1) + 1;
  localparam int Y_W = $clog2(V_LINES + 1);

  state_t          state_q, state_d;
  logic            vs_q, vs_prev_q, hr_q, hr_prev_q;
  logic [7:0]      d_q;
  logic [X_W-1:0]  x_q, x_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [15:0]     dout_q, dout_d;
  logic            fd_q, fd_d;
  logic            lerr_q, lerr_d;
  logic            ovf_q, ovf_d;

  logic            vs_fall, vs_rise, hr_fall, asm_en, pix_valid, keep;
  logic [15:0]     pix;

  assign vs_fall = vs_prev_q & ~vs_q;
  assign vs_rise = ~vs_prev_q & vs_q;
  assign hr_fall = hr_prev_q & ~hr_q;
  assign asm_en  = (state_q == ACTIVE) & bus.config_finished & hr_q & ~vs_rise;
  assign keep    = (SUBSAMPLE == 1) || (!x_q[0] && !y_q[0]);

  ov7670_byte_assembler u_asm (
    .clk         (clk),
    .reset       (reset),
    .en_i        (asm_en),
    .d_i         (d_q),
    .pix_valid_o (pix_valid),
    .pix_o       (pix)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    dout_d  = dout_q;
    fd_d    = 1'b0;
    lerr_d  = lerr_q;
    ovf_d   = ovf_q;
    // The address advances the cycle after the strobe so addr reads as the write address.
    if (we_q) cnt_d = cnt_q + 1'b1;
    case (state_q)
      WAIT_CFG: begin
        if (bus.config_finished) state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (vs_fall) begin
          state_d = ACTIVE;
          x_d     = '0;
          y_d     = '0;
          cnt_d   = '0;
          lerr_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      ACTIVE: begin
        if (vs_rise) begin
          state_d = WAIT_FRAME;
          fd_d    = 1'b1;
        end else begin
          if (pix_valid) begin
            if (x_q != '1) x_d = x_q + 1'b1;
            if (y_q == Y_W'(V_LINES)) begin
              ovf_d = 1'b1;
            end else if (keep) begin
              if (cnt_q <= (ADDR_W+1)'(MAX_ADDR)) begin
                we_d   = 1'b1;
                dout_d = pix;
              end else begin
                ovf_d = 1'b1;
              end
            end
          end
          if (hr_fall) begin
            if (x_q != X_W'(H_PIXELS)) lerr_d = 1'b1;
            x_d = '0;
            if (y_q != Y_W'(V_LINES)) y_d = y_q + 1'b1;
          end
        end
      end
      default: state_d = WAIT_CFG;
    endcase
    if (!bus.config_finished) begin
      state_d = WAIT_CFG;
      we_d    = 1'b0;
      fd_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= WAIT_CFG;
      vs_q      <= 1'b0;
      vs_prev_q <= 1'b0;
      hr_q      <= 1'b0;
      hr_prev_q <= 1'b0;
      d_q       <= 8'h00;
      x_q       <= '0;
      y_q       <= '0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      dout_q    <= 16'h0000;
      fd_q      <= 1'b0;
      lerr_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      vs_q      <= bus.vsync;
      vs_prev_q <= vs_q;
      hr_q      <= bus.href;
      hr_prev_q <= hr_q;
      d_q       <= bus.d;
      x_q       <= x_d;
      y_q       <= y_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      dout_q    <= dout_d;
      fd_q      <= fd_d;
      lerr_q    <= lerr_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.we         = we_q;
  assign bus.addr       = cnt_q[ADDR_W-1:0];
  assign bus.dout       = dout_q;
  assign bus.frame_done = fd_q;
  assign bus.line_err   = lerr_q;
  assign bus.overflow   = ovf_q;
  assign bus.capturing  = (state_q == ACTIVE);

endmodule
`default_nettype wire

// File: tb/tb_ov7670_capture_left.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ov7670_capture_left : directed bench, 4x2 full and 4x4 2:1 DUTs |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_ov7670_capture_left;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg, vsync, href;
  logic [7:0] d;

  int checks = 0;
  int fails  = 0;

  ov7670_capture_left_if #(.ADDR_W(8)) bus1 ();
  ov7670_capture_left_if #(.ADDR_W(8)) bus2 ();

  assign bus1.config_finished = cfg;
  assign bus1.vsync           = vsync;
  assign bus1.href            = href;
  assign bus1.d               = d;
  assign bus2.config_finished = cfg;
  assign bus2.vsync           = vsync;
  assign bus2.href            = href;
  assign bus2.d               = d;

  ov7670_capture_left #(.H_PIXELS(4), .V_LINES(2), .SUBSAMPLE(1), .ADDR_W(8)) dut1 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus1)
  );

  ov7670_capture_left #(.H_PIXELS(4), .V_LINES(4), .SUBSAMPLE(2), .ADDR_W(8)) dut2 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus2)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] L0 = 64'h12345678_9ABCDEF0;
  localparam logic [63:0] L1 = 64'h21436587_A9CBED0F;
  localparam logic [63:0] L2 = 64'h11223344_55667788;

  logic [7:0]  w1_addr [256];
  logic [15:0] w1_dout [256];
  logic [7:0]  w2_addr [256];
  logic [15:0] w2_dout [256];
  int n1 = 0, n2 = 0, fd1 = 0, fd2 = 0, cap1 = 0;

  always @(negedge clk) begin
    if (bus1.we === 1'b1 && n1 < 256) begin
      w1_addr[n1] = bus1.addr;
      w1_dout[n1] = bus1.dout;
      n1 = n1 + 1;
    end
    if (bus2.we === 1'b1 && n2 < 256) begin
      w2_addr[n2] = bus2.addr;
      w2_dout[n2] = bus2.dout;
      n2 = n2 + 1;
    end
    if (bus1.frame_done === 1'b1) fd1 = fd1 + 1;
    if (bus2.frame_done === 1'b1) fd2 = fd2 + 1;
    if (bus1.capturing === 1'b1) cap1 = cap1 + 1;
  end

  task automatic drive_line(input logic [63:0] bytes, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      href = 1'b1;
      d    = bytes[63-8*k -: 8];
    end
    @(negedge clk);
    href = 1'b0;
    d    = 8'h00;
    repeat (3) @(negedge clk);
  endtask

  task automatic frame_start();
    @(negedge clk);
    vsync = 1'b1;
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end();
    @(negedge clk);
    vsync = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg = 1'b0; vsync = 1'b1; href = 1'b0; d = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (bus1.we !== 1'b0) begin fails++; $display("FAIL reset_we: got %b expected 0", bus1.we); end
    checks++; if (bus1.addr !== 8'h00) begin fails++; $display("FAIL reset_addr: got %h expected 00", bus1.addr); end
    checks++; if (bus1.dout !== 16'h0000) begin fails++; $display("FAIL reset_dout: got %h expected 0000", bus1.dout); end
    checks++; if ({bus1.frame_done, bus1.line_err, bus1.overflow, bus1.capturing} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags: got %b expected 0000",
                        {bus1.frame_done, bus1.line_err, bus1.overflow, bus1.capturing});
    end
    checks++; if ({bus2.we, bus2.capturing, bus2.overflow} !== 3'b000) begin
      fails++; $display("FAIL reset_dut2: got %b expected 000", {bus2.we, bus2.capturing, bus2.overflow});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_no_config();
    int s1, s2, c1, f1;
    s1 = n1; s2 = n2; c1 = cap1; f1 = fd1;
    frame_start();
    drive_line(L0, 8);
    drive_line(L1, 8);
    frame_end();
    checks++; if (n1 - s1 != 0) begin fails++; $display("FAIL nocfg_we1: got %0d writes expected 0", n1 - s1); end
    checks++; if (n2 - s2 != 0) begin fails++; $display("FAIL nocfg_we2: got %0d writes expected 0", n2 - s2); end
    checks++; if (cap1 - c1 != 0) begin fails++; $display("FAIL nocfg_capturing: got %0d cycles expected 0", cap1 - c1); end
    checks++; if (fd1 - f1 != 0) begin fails++; $display("FAIL nocfg_frame_done: got %0d expected 0", fd1 - f1); end
  endtask

  task automatic test_full_frame();
    logic [15:0] exp_d [8];
    int s1, s2, f1;
    exp_d = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h2143, 16'h6587, 16'hA9CB, 16'hED0F};
    cfg = 1'b1;
    repeat (3) @(negedge clk);
    s1 = n1; s2 = n2; f1 = fd1;
    frame_start();
    checks++; if (bus1.capturing !== 1'b1) begin fails++; $display("FAIL full_capturing: got %b expected 1", bus1.capturing); end
    drive_line(L0, 8);
    drive_line(L1, 8);
    frame_end();
    checks++; if (n1 - s1 != 8) begin fails++; $display("FAIL full_count: got %0d writes expected 8", n1 - s1); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (w1_addr[s1+i] !== 8'(i) || w1_dout[s1+i] !== exp_d[i]) begin
        fails++; $display("FAIL full_write%0d: got addr %h dout %h expected addr %h dout %h",
                          i, w1_addr[s1+i], w1_dout[s1+i], 8'(i), exp_d[i]);
      end
    end
    checks++; if (fd1 - f1 != 1) begin fails++; $display("FAIL full_frame_done: got %0d pulses expected 1", fd1 - f1); end
    checks++; if ({bus1.line_err, bus1.overflow, bus1.capturing} !== 3'b000) begin
      fails++; $display("FAIL full_flags: got %b expected 000", {bus1.line_err, bus1.overflow, bus1.capturing});
    end
    checks++; if (n2 - s2 != 2 || w2_dout[s2] !== 16'h1234 || w2_dout[s2+1] !== 16'h9ABC) begin
      fails++; $display("FAIL full_dut2: got %0d writes %h %h expected 2 writes 1234 9abc",
                        n2 - s2, w2_dout[s2], w2_dout[s2+1]);
    end
  endtask

  task automatic test_subsample();
    logic [15:0] exp_d [4];
    int s2;
    exp_d = '{16'h1234, 16'h9ABC, 16'h1122, 16'h5566};
    s2 = n2;
    frame_start();
    drive_line(L0, 8);
    drive_line(L1, 8);
    drive_line(L2, 8);
    drive_line(L1, 8);
    frame_end();
    checks++; if (n2 - s2 != 4) begin fails++; $display("FAIL sub_count: got %0d writes expected 4", n2 - s2); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (w2_addr[s2+i] !== 8'(i) || w2_dout[s2+i] !== exp_d[i]) begin
        fails++; $display("FAIL sub_write%0d: got addr %h dout %h expected addr %h dout %h",
                          i, w2_addr[s2+i], w2_dout[s2+i], 8'(i), exp_d[i]);
      end
    end
    checks++; if (bus2.overflow !== 1'b0 || bus2.line_err !== 1'b0) begin
      fails++; $display("FAIL sub_flags: got ovf %b lerr %b expected 0 0", bus2.overflow, bus2.line_err);
    end
  endtask

  task automatic test_line_err();
    int s1;
    s1 = n1;
    frame_start();
    drive_line(L0, 7);
    drive_line(L1, 8);
    frame_end();
    checks++; if (bus1.line_err !== 1'b1) begin fails++; $display("FAIL lerr_set: got %b expected 1", bus1.line_err); end
    checks++; if (n1 - s1 != 7) begin fails++; $display("FAIL lerr_count: got %0d writes expected 7", n1 - s1); end
    checks++; if (w1_dout[s1+2] !== 16'h9ABC || w1_addr[s1+3] !== 8'h03 || w1_dout[s1+3] !== 16'h2143) begin
      fails++; $display("FAIL lerr_drop: got %h @%h then %h expected 9abc then 2143 @03",
                        w1_dout[s1+2], w1_addr[s1+3], w1_dout[s1+3]);
    end
    frame_start();
    checks++; if (bus1.line_err !== 1'b0) begin fails++; $display("FAIL lerr_clear: got %b expected 0", bus1.line_err); end
    drive_line(L0, 8);
    drive_line(L1, 8);
    frame_end();
  endtask

  task automatic test_overflow();
    int s1;
    s1 = n1;
    frame_start();
    drive_line(L0, 8);
    drive_line(L1, 8);
    drive_line(L2, 8);
    frame_end();
    checks++; if (n1 - s1 != 8) begin fails++; $display("FAIL ovf_count: got %0d writes expected 8", n1 - s1); end
    checks++; if (bus1.overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b expected 1", bus1.overflow); end
    checks++; if (bus1.addr !== 8'h08) begin fails++; $display("FAIL ovf_addr: got %h expected 08", bus1.addr); end
  endtask

  task automatic test_reset_mid();
    int s1, f1;
    frame_start();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      href = 1'b1;
      d    = L0[63-8*k -: 8];
    end
    rst = 1'b1;
    @(negedge clk);
    s1 = n1; f1 = fd1;
    checks++; if ({bus1.we, bus1.capturing, bus1.line_err, bus1.overflow} !== 4'b0000 || bus1.addr !== 8'h00) begin
      fails++; $display("FAIL midrst_outputs: got flags %b addr %h expected 0000 addr 00",
                        {bus1.we, bus1.capturing, bus1.line_err, bus1.overflow}, bus1.addr);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 5; k < 8; k++) begin
      @(negedge clk);
      d = L0[63-8*k -: 8];
    end
    @(negedge clk);
    href = 1'b0;
    repeat (3) @(negedge clk);
    drive_line(L1, 8);
    frame_end();
    checks++; if (n1 - s1 != 0) begin fails++; $display("FAIL midrst_nowrite: got %0d writes expected 0", n1 - s1); end
    checks++; if (fd1 - f1 != 0) begin fails++; $display("FAIL midrst_nodone: got %0d pulses expected 0", fd1 - f1); end
    frame_start();
    drive_line(L0, 8);
    frame_end();
    checks++; if (n1 - s1 != 4) begin fails++; $display("FAIL midrst_resume: got %0d writes expected 4", n1 - s1); end
    checks++; if (w1_addr[s1] !== 8'h00 || w1_dout[s1] !== 16'h1234) begin
      fails++; $display("FAIL midrst_first: got addr %h dout %h expected addr 00 dout 1234", w1_addr[s1], w1_dout[s1]);
    end
  endtask

  initial begin
    test_reset();
    test_no_config();
    test_full_frame();
    test_subsample();
    test_line_err();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
